dual_fetch_ctrl: RTL

//  Fetch sequencer for the 2-way superscalar front end. It owns the fetch PC and drives the
//  PC/PC4 address pair of the dual-read instruction memory. Returned instr1/instr2 words go

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_queue.sv | 58 +++++
 rtl/dual_fetch_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the dual-issue fetch front end: queue entry layout, FSM states
// and the decode-take clamp shared by the controller.
package fetch_pkg;
   localparam int FETCH_W = 2;
   localparam int INSTR_W = 32;
   localparam int PC_W    = 64;

   typedef enum logic {
      S_BOOT = 1'b0,
      S_RUN  = 1'b1
   } state_e;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fq_entry_t;

   // Decode may only take what is visible; 3 and over-takes collapse to the legal maximum.
   function automatic logic [1:0] clamp_take(input logic [1:0] take,
                                             input logic ge1, input logic ge2);
      logic [1:0] r;
      r = 2'd0;
      if (ge2)      r = (take == 2'd3) ? 2'd2 : take;
      else if (ge1) r = (take != 2'd0) ? 2'd1 : 2'd0;
      return r;
   endfunction
endpackage

// File: rtl/fetch_queue.sv
// QDEPTH-entry circular instruction buffer with two write and two read ports.
// Flush empties the queue by snapping head onto tail.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter  int QDEPTH = 4,
   localparam int AW     = $clog2(QDEPTH)
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_flush,
   input  logic [1:0] i_push_cnt,
   input  logic [1:0] i_pop_cnt,
   input  fq_entry_t  i_wdata0,
   input  fq_entry_t  i_wdata1,
   output fq_entry_t  o_rdata0,
   output fq_entry_t  o_rdata1,
   output logic       o_valid0,
   output logic       o_valid1,
   output logic [AW:0] o_count
);
   fq_entry_t       r_mem [QDEPTH];
   logic [AW-1:0]   r_head, r_tail;
   logic [AW:0]     r_count;
   logic [AW-1:0]   w_head1, w_tail1;
   logic            w_wr_en;

   assign w_head1 = r_head + AW'(1);
   assign w_tail1 = r_tail + AW'(1);
   assign w_wr_en = !i_rst && !i_flush;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_head  <= r_tail;
         r_count <= '0;
      end else begin
         r_head  <= r_head + AW'(i_pop_cnt);
         r_tail  <= r_tail + AW'(i_push_cnt);
         r_count <= r_count - (AW+1)'(i_pop_cnt) + (AW+1)'(i_push_cnt);
      end
   end

   // Storage is not reset: slots are only observed once count covers them.
   always_ff @(posedge i_clk) begin
      if (w_wr_en && i_push_cnt != 2'd0) r_mem[r_tail]  <= i_wdata0;
      if (w_wr_en && i_push_cnt == 2'd2) r_mem[w_tail1] <= i_wdata1;
   end

   assign o_count  = r_count;
   assign o_valid0 = (r_count != '0);
   assign o_valid1 = (r_count >= (AW+1)'(2));
   assign o_rdata0 = o_valid0 ? r_mem[r_head]  : '0;
   assign o_rdata1 = o_valid1 ? r_mem[w_head1] : '0;
endmodule

// File: rtl/dual_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, drives the PC/PC+4 pair to instruction memory
// and fills the instruction queue with as many words as there are free slots.
module dual_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int              XLEN     = 64,
   parameter int              QDEPTH   = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_branch_en,
   input  logic [XLEN-1:0]    i_branch_pc,
   output logic [XLEN-1:0]    o_imem_pc,
   output logic [XLEN-1:0]    o_imem_pc4,
   input  logic [INSTR_W-1:0] i_imem_instr1,
   input  logic [INSTR_W-1:0] i_imem_instr2,
   output logic               o_out_valid0,
   output logic [XLEN-1:0]    o_out_pc0,
   output logic [INSTR_W-1:0] o_out_instr0,
   output logic               o_out_valid1,
   output logic [XLEN-1:0]    o_out_pc1,
   output logic [INSTR_W-1:0] o_out_instr1,
   input  logic [1:0]         i_dec_take
);
   localparam int              AW         = $clog2(QDEPTH);
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

   state_e          r_state, w_state_nxt;
   logic [XLEN-1:0] r_fetch_pc, w_fetch_pc_nxt;
   logic [1:0]      w_taken, w_push_cnt, w_pop_cnt;
   logic [AW:0]     w_count;
   logic [AW+1:0]   w_free;
   logic            w_valid0, w_valid1, w_take_ok;
   fq_entry_t       w_wd0, w_wd1, w_rd0, w_rd1;

   assign w_taken = clamp_take(i_dec_take, w_valid0, w_valid1);
   // Slots released by this cycle's dequeue are reusable in the same cycle.
   assign w_free  = (AW+2)'(QDEPTH) - {1'b0, w_count} + (AW+2)'(w_taken);

   always_comb begin
      w_state_nxt    = r_state;
      w_fetch_pc_nxt = r_fetch_pc;
      w_push_cnt     = 2'd0;
      w_pop_cnt      = w_taken;
      unique case (r_state)
         S_BOOT: w_state_nxt = S_RUN;
         S_RUN: begin
            if (w_free >= (AW+2)'(2)) begin
               w_push_cnt     = 2'd2;
               w_fetch_pc_nxt = r_fetch_pc + XLEN'(8);
            end else if (w_free == (AW+2)'(1)) begin
               w_push_cnt     = 2'd1;
               w_fetch_pc_nxt = r_fetch_pc + XLEN'(4);
            end
         end
         default: w_state_nxt = S_BOOT;
      endcase
      if (i_branch_en) begin
         w_state_nxt    = S_RUN;
         w_fetch_pc_nxt = i_branch_pc & ALIGN_MASK;
         w_push_cnt     = 2'd0;
         w_pop_cnt      = 2'd0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_BOOT;
         r_fetch_pc <= RESET_PC & ALIGN_MASK;
      end else begin
         r_state    <= w_state_nxt;
         r_fetch_pc <= w_fetch_pc_nxt;
      end
   end

   assign w_take_ok = (i_dec_take == 2'd0) || (i_dec_take == 2'd1 && w_valid0) ||
                      (i_dec_take == 2'd2 && w_valid1);
   always_ff @(posedge i_clk) begin
      if (!i_rst) assert (w_take_ok);
   end

   assign w_wd0 = '{pc: PC_W'(r_fetch_pc),            instr: i_imem_instr1};
   assign w_wd1 = '{pc: PC_W'(r_fetch_pc + XLEN'(4)), instr: i_imem_instr2};

   fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_flush    (i_branch_en),
      .i_push_cnt (w_push_cnt),
      .i_pop_cnt  (w_pop_cnt),
      .i_wdata0   (w_wd0),
      .i_wdata1   (w_wd1),
      .o_rdata0   (w_rd0),
      .o_rdata1   (w_rd1),
      .o_valid0   (w_valid0),
      .o_valid1   (w_valid1),
      .o_count    (w_count)
   );

   assign o_imem_pc    = r_fetch_pc;
   assign o_imem_pc4   = r_fetch_pc + XLEN'(4);
   assign o_out_valid0 = w_valid0;
   assign o_out_pc0    = XLEN'(w_rd0.pc);
   assign o_out_instr0 = w_rd0.instr;
   assign o_out_valid1 = w_valid1;
   assign o_out_pc1    = XLEN'(w_rd1.pc);
   assign o_out_instr1 = w_rd1.instr;
endmodule
